// File: rtl/top_module_rca_pkg.sv
// ============================================================================
// Module   : top_module_rca_pkg
// Brief    : Shared width and result types for the registered ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_module_rca_pkg;

  localparam int ADDER_W = 4;

  typedef logic [ADDER_W-1:0] operand_t;

  typedef struct {
    operand_t sum;
    logic     cout;
    logic     ovf;
  } add_result_t;

endpackage

`default_nettype wire

// File: rtl/top_module_rca_full_adder.sv
// ============================================================================
// Module   : full_adder
// Brief    : Single-bit full-adder cell, one link of the ripple-carry chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/top_module_rca.sv
// ============================================================================
// Module   : top_module_rca
// Brief    : Registered WIDTH-bit ripple-carry adder with carry-in/carry-out.
//            Optional signed-overflow output enabled by TOP_MODULE_RCA_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_module_rca
  import top_module_rca_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef TOP_MODULE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef TOP_MODULE_RCA_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_top_module_rca.sv
// ============================================================================
// Module   : tb_top_module_rca
// Brief    : Directed and exhaustive bench for top_module_rca; covers the
//            TOP_MODULE_RCA_OVF_EN build when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_module_rca;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
`ifdef TOP_MODULE_RCA_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  top_module_rca #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
`ifdef TOP_MODULE_RCA_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one operand set, clock it in, then check the registered result.
  task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic [3:0] es, input logic ec);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    check_val({tag, "_sum"},  {4'h0, sum},  {4'h0, es});
    check_val({tag, "_cout"}, {7'h0, cout}, {7'h0, ec});
  endtask

  initial begin
    logic [4:0] exp_full;
    logic       exp_ovf;

    rst_n = 1'b0;
    a     = 4'hF;
    b     = 4'hF;
    cin   = 1'b1;

    // Reset held for two edges with maximal operands
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("rst_sum",  {4'h0, sum},  8'h00);
    check_val("rst_cout", {7'h0, cout}, 8'h00);
`ifdef TOP_MODULE_RCA_OVF_EN
    check_val("rst_ovf",  {7'h0, ovf},  8'h00);
`endif

    rst_n = 1'b1;
    apply("post_rst", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);

    // Corner sums
    apply("f_plus_1",  4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    apply("cin_only",  4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
    apply("7_8_cin",   4'h7, 4'h8, 1'b1, 4'h0, 1'b1);

`ifdef TOP_MODULE_RCA_OVF_EN
    apply("ovf_pos", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
    check_val("ovf_pos_ovf", {7'h0, ovf}, 8'h01);
    apply("ovf_neg", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
    check_val("ovf_neg_ovf", {7'h0, ovf}, 8'h01);
    apply("no_ovf",  4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    check_val("no_ovf_ovf", {7'h0, ovf}, 8'h00);
`endif

    // Exhaustive back-to-back sweep, one vector per cycle
    for (int c = 0; c < 2; c++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          exp_full = 5'(ia) + 5'(ib) + 5'(c);
          apply("sweep", 4'(ia), 4'(ib), 1'(c), exp_full[3:0], exp_full[4]);
`ifdef TOP_MODULE_RCA_OVF_EN
          exp_ovf = (ia[3] == ib[3]) && (exp_full[3] != ia[3]);
          check_val("sweep_ovf", {7'h0, ovf}, {7'h0, exp_ovf});
`endif
        end
      end
    end

    // Low pulse between edges must not be sampled
    apply("pre_glitch", 4'h5, 4'h6, 1'b0, 4'hB, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check_val("glitch_hold", {3'h0, cout, sum}, 8'h0B);
    apply("post_glitch", 4'h2, 4'h3, 1'b1, 4'h6, 1'b0);

    // Mid-stream reset discards the in-flight 3+4
    a     = 4'h3;
    b     = 4'h4;
    cin   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rst_sum",  {4'h0, sum},  8'h00);
    check_val("mid_rst_cout", {7'h0, cout}, 8'h00);
    rst_n = 1'b1;
    apply("after_mid_rst", 4'h9, 4'h9, 1'b0, 4'h2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
